// File: rtl/sparse_intersect_unit_if.sv
// rtl/sparse_intersect_unit_if.sv - token stream bundle for sparse_intersect_unit
// Carries two coord/pos input fibers and the three merged output streams.
interface sparse_intersect_unit_if;
    logic [16:0] coord_in_0;
    logic        coord_in_0_valid;
    logic        coord_in_0_ready;
    logic [16:0] pos_in_0;
    logic        pos_in_0_valid;
    logic        pos_in_0_ready;
    logic [16:0] coord_in_1;
    logic        coord_in_1_valid;
    logic        coord_in_1_ready;
    logic [16:0] pos_in_1;
    logic        pos_in_1_valid;
    logic        pos_in_1_ready;
    logic [16:0] coord_out;
    logic        coord_out_valid;
    logic        coord_out_ready;
    logic [16:0] pos_out_0;
    logic        pos_out_0_valid;
    logic        pos_out_0_ready;
    logic [16:0] pos_out_1;
    logic        pos_out_1_valid;
    logic        pos_out_1_ready;

    modport master (
        output coord_in_0, coord_in_0_valid, pos_in_0, pos_in_0_valid,
        output coord_in_1, coord_in_1_valid, pos_in_1, pos_in_1_valid,
        output coord_out_ready, pos_out_0_ready, pos_out_1_ready,
        input  coord_in_0_ready, pos_in_0_ready, coord_in_1_ready, pos_in_1_ready,
        input  coord_out, coord_out_valid, pos_out_0, pos_out_0_valid,
        input  pos_out_1, pos_out_1_valid
    );

    modport slave (
        input  coord_in_0, coord_in_0_valid, pos_in_0, pos_in_0_valid,
        input  coord_in_1, coord_in_1_valid, pos_in_1, pos_in_1_valid,
        input  coord_out_ready, pos_out_0_ready, pos_out_1_ready,
        output coord_in_0_ready, pos_in_0_ready, coord_in_1_ready, pos_in_1_ready,
        output coord_out, coord_out_valid, pos_out_0, pos_out_0_valid,
        output pos_out_1, pos_out_1_valid
    );
endinterface

// File: rtl/sparse_intersect_unit.sv
// rtl/sparse_intersect_unit.sv - two-fiber sparse intersect/union joiner
// Optional INTERSECT_CYCLE_COUNT_EN adds a 64-bit cycle_count output.
module sparse_intersect_unit (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_en,
    input  logic flush,
    input  logic tile_en,
    input  logic joiner_op,
    input  logic value_mode,
    sparse_intersect_unit_if.slave bus
`ifdef INTERSECT_CYCLE_COUNT_EN
    ,
    output logic [63:0] cycle_count
`endif
);
    localparam logic [16:0] TOK_D = 17'h10100;
    localparam logic [16:0] TOK_E = 17'h10200;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;

    logic [16:0] mem [3][2];
    logic [1:0]  cnt [3];
    logic [2:0]  rd_ptr;
    logic [16:0] tok [3];
    logic [2:0]  out_pop;

    logic [16:0] c0, c1, p0, p1, fill;
    logic [7:0]  lvl;
    logic        avail0, avail1, data0, data1, is_d0, is_d1;
    logic        room, out_en, fire, pop0, pop1, emit, last, push;

    assign c0     = bus.coord_in_0;
    assign c1     = bus.coord_in_1;
    assign p0     = bus.pos_in_0;
    assign p1     = bus.pos_in_1;
    assign avail0 = bus.coord_in_0_valid & bus.pos_in_0_valid;
    assign avail1 = bus.coord_in_1_valid & bus.pos_in_1_valid;
    assign data0  = ~c0[16];
    assign data1  = ~c1[16];
    assign is_d0  = (c0 == TOK_D);
    assign is_d1  = (c1 == TOK_D);
    assign fill   = value_mode ? 17'h00000 : TOK_E;
    assign lvl    = (c0[7:0] > c1[7:0]) ? c0[7:0] : c1[7:0];

    assign out_en = tile_en & clk_en;
    assign room   = (cnt[0] != 2'd2) & (cnt[1] != 2'd2) & (cnt[2] != 2'd2);
    assign fire   = out_en & ~flush & (state == RUN) & room & avail0 & avail1;
    assign push   = fire & emit;

    // Head comparison picks which side(s) to pop and what, if anything, to emit.
    always_comb begin
        pop0   = 1'b0;
        pop1   = 1'b0;
        emit   = 1'b0;
        last   = 1'b0;
        tok[0] = '0;
        tok[1] = '0;
        tok[2] = '0;
        if (data0 && data1) begin
            if (c0[15:0] == c1[15:0]) begin
                pop0 = 1'b1; pop1 = 1'b1; emit = 1'b1;
                tok[0] = c0; tok[1] = p0; tok[2] = p1;
            end else if (c0[15:0] < c1[15:0]) begin
                pop0 = 1'b1; emit = joiner_op;
                tok[0] = c0; tok[1] = p0; tok[2] = fill;
            end else begin
                pop1 = 1'b1; emit = joiner_op;
                tok[0] = c1; tok[1] = fill; tok[2] = p1;
            end
        end else if (data0) begin
            pop0 = 1'b1; emit = joiner_op;
            tok[0] = c0; tok[1] = p0; tok[2] = fill;
        end else if (data1) begin
            pop1 = 1'b1; emit = joiner_op;
            tok[0] = c1; tok[1] = fill; tok[2] = p1;
        end else if (is_d0 && is_d1) begin
            pop0 = 1'b1; pop1 = 1'b1; emit = 1'b1; last = 1'b1;
            tok[0] = TOK_D; tok[1] = TOK_D; tok[2] = TOK_D;
        end else if (is_d0) begin
            pop1 = 1'b1;
        end else if (is_d1) begin
            pop0 = 1'b1;
        end else begin
            pop0 = 1'b1; pop1 = 1'b1; emit = 1'b1;
            tok[0] = {9'h100, lvl}; tok[1] = {9'h100, lvl}; tok[2] = {9'h100, lvl};
        end
    end

    assign bus.coord_in_0_ready = fire & pop0;
    assign bus.pos_in_0_ready   = fire & pop0;
    assign bus.coord_in_1_ready = fire & pop1;
    assign bus.pos_in_1_ready   = fire & pop1;

    assign bus.coord_out       = mem[0][rd_ptr[0]];
    assign bus.pos_out_0       = mem[1][rd_ptr[1]];
    assign bus.pos_out_1       = mem[2][rd_ptr[2]];
    assign bus.coord_out_valid = out_en & (cnt[0] != 2'd0);
    assign bus.pos_out_0_valid = out_en & (cnt[1] != 2'd0);
    assign bus.pos_out_1_valid = out_en & (cnt[2] != 2'd0);

    assign out_pop = {bus.pos_out_1_valid & bus.pos_out_1_ready,
                      bus.pos_out_0_valid & bus.pos_out_0_ready,
                      bus.coord_out_valid & bus.coord_out_ready};

    // Write slot is rd_ptr offset by occupancy; push never happens when full.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rd_ptr <= '0;
            for (int k = 0; k < 3; k++) begin
                cnt[k]    <= '0;
                mem[k][0] <= '0;
                mem[k][1] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            for (int k = 0; k < 3; k++) begin
                cnt[k]    <= '0;
                mem[k][0] <= '0;
                mem[k][1] <= '0;
            end
        end else if (clk_en) begin
            for (int k = 0; k < 3; k++) begin
                if (push) mem[k][rd_ptr[k] ^ cnt[k][0]] <= tok[k];
                if (out_pop[k]) rd_ptr[k] <= ~rd_ptr[k];
                cnt[k] <= cnt[k] + {1'b0, push} - {1'b0, out_pop[k]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= IDLE;
        end else if (flush) begin
            state <= IDLE;
        end else if (clk_en) begin
            if (!tile_en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE:    if (avail0 || avail1) state <= RUN;
                    RUN:     if (fire && last) state <= DONE;
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef INTERSECT_CYCLE_COUNT_EN
    logic cc_run, cc_stop, any_valid;
    assign any_valid = bus.coord_in_0_valid | bus.pos_in_0_valid |
                       bus.coord_in_1_valid | bus.pos_in_1_valid;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cycle_count <= '0;
            cc_run      <= 1'b0;
            cc_stop     <= 1'b0;
        end else if (flush) begin
            cycle_count <= '0;
            cc_run      <= 1'b0;
            cc_stop     <= 1'b0;
        end else if (clk_en) begin
            if (!cc_stop && (cc_run || any_valid)) begin
                cycle_count <= cycle_count + 64'd1;
                cc_run      <= 1'b1;
            end
            if (out_pop[1] && bus.pos_out_0 == TOK_D) cc_stop <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_sparse_intersect_unit.sv
// tb/tb_sparse_intersect_unit.sv - self-checking bench for sparse_intersect_unit
// Fixed vectors, backpressure/freeze/reset sequences and random fibers vs a merge model.
module tb_sparse_intersect_unit;
    localparam logic [16:0] S0 = 17'h10000;
    localparam logic [16:0] S1 = 17'h10001;
    localparam logic [16:0] DN = 17'h10100;
    localparam logic [16:0] EE = 17'h10200;
    localparam logic [16:0] Z  = 17'h00000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clk_en = 1'b1;
    logic flush = 1'b0;
    logic tile_en = 1'b1;
    logic joiner_op = 1'b0;
    logic value_mode = 1'b0;
`ifdef INTERSECT_CYCLE_COUNT_EN
    logic [63:0] cycle_count;
`endif

    sparse_intersect_unit_if bus();

    sparse_intersect_unit dut (
        .clk(clk),
        .rst_n(rst_n),
        .clk_en(clk_en),
        .flush(flush),
        .tile_en(tile_en),
        .joiner_op(joiner_op),
        .value_mode(value_mode),
        .bus(bus)
`ifdef INTERSECT_CYCLE_COUNT_EN
        ,
        .cycle_count(cycle_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    logic [16:0] q0c[$], q0p[$], q1c[$], q1p[$];
    logic [16:0] got_c[$], got_p0[$], got_p1[$];
    logic [16:0] exp_c[$], exp_p0[$], exp_p1[$];

    typedef struct {
        logic op;
        logic vm;
        int   n0;
        int   n1;
        int   nc;
        logic [0:7][16:0] c0, p0, c1, p1, ec, ep0, ep1;
    } vec_t;
    vec_t vt[4];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cmp_q(input string nm, input logic [16:0] got[$], input logic [16:0] exp[$]);
        check({nm, " len"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s[%0d]", nm, i), 64'(got[i]), 64'(exp[i]));
    endtask

    task automatic cmp_all(input string nm);
        cmp_q({nm, " coord"}, got_c, exp_c);
        cmp_q({nm, " pos0"}, got_p0, exp_p0);
        cmp_q({nm, " pos1"}, got_p1, exp_p1);
    endtask

    task automatic drive_idle();
        bus.coord_in_0 = '0; bus.pos_in_0 = '0; bus.coord_in_0_valid = 0; bus.pos_in_0_valid = 0;
        bus.coord_in_1 = '0; bus.pos_in_1 = '0; bus.coord_in_1_valid = 0; bus.pos_in_1_valid = 0;
        bus.coord_out_ready = 1; bus.pos_out_0_ready = 1; bus.pos_out_1_ready = 1;
    endtask

    task automatic load_vec(input int t);
        q0c.delete(); q0p.delete(); q1c.delete(); q1p.delete();
        exp_c.delete(); exp_p0.delete(); exp_p1.delete();
        for (int i = 0; i < vt[t].n0; i++) begin q0c.push_back(vt[t].c0[i]); q0p.push_back(vt[t].p0[i]); end
        for (int i = 0; i < vt[t].n1; i++) begin q1c.push_back(vt[t].c1[i]); q1p.push_back(vt[t].p1[i]); end
        for (int i = 0; i < vt[t].nc; i++) begin
            exp_c.push_back(vt[t].ec[i]); exp_p0.push_back(vt[t].ep0[i]); exp_p1.push_back(vt[t].ep1[i]);
        end
    endtask

    task automatic run_stream(input int budget, input bit rnd, input int hold1, input int stop_after,
                              output bit timed_out);
        int cyc;
        bit v0, v1;
        cyc = 0;
        timed_out = 0;
        got_c.delete(); got_p0.delete(); got_p1.delete();
        forever begin
            @(negedge clk);
            v0 = (q0c.size() > 0) && (!rnd || $urandom_range(3) != 0);
            v1 = (q1c.size() > 0) && (!rnd || $urandom_range(3) != 0);
            bus.coord_in_0 = v0 ? q0c[0] : Z;  bus.pos_in_0 = v0 ? q0p[0] : Z;
            bus.coord_in_1 = v1 ? q1c[0] : Z;  bus.pos_in_1 = v1 ? q1p[0] : Z;
            bus.coord_in_0_valid = v0; bus.pos_in_0_valid = v0;
            bus.coord_in_1_valid = v1; bus.pos_in_1_valid = v1;
            bus.coord_out_ready = !rnd || $urandom_range(3) != 0;
            bus.pos_out_0_ready = !rnd || $urandom_range(3) != 0;
            bus.pos_out_1_ready = (cyc < hold1) ? 1'b0 : (!rnd || $urandom_range(3) != 0);
            #1;
            if (hold1 > 0 && cyc == hold1 - 1) begin
                check("bp coord_in_0_ready", 64'(bus.coord_in_0_ready), 64'd0);
                check("bp coord_in_1_ready", 64'(bus.coord_in_1_ready), 64'd0);
                check("bp coord tokens <= 2", 64'(got_c.size() <= 2), 64'd1);
                check("bp pos_out_1 held", 64'(got_p1.size()), 64'd0);
                check("bp pos_out_1_valid", 64'(bus.pos_out_1_valid), 64'd1);
            end
            if (bus.coord_in_0_valid && bus.coord_in_0_ready) begin
                void'(q0c.pop_front()); void'(q0p.pop_front());
            end
            if (bus.coord_in_1_valid && bus.coord_in_1_ready) begin
                void'(q1c.pop_front()); void'(q1p.pop_front());
            end
            if (bus.coord_out_valid && bus.coord_out_ready) got_c.push_back(bus.coord_out);
            if (bus.pos_out_0_valid && bus.pos_out_0_ready) got_p0.push_back(bus.pos_out_0);
            if (bus.pos_out_1_valid && bus.pos_out_1_ready) got_p1.push_back(bus.pos_out_1);
            cyc++;
            if (got_c.size() > 0 && got_p0.size() > 0 && got_p1.size() > 0 &&
                got_c[$] == DN && got_p0[$] == DN && got_p1[$] == DN) break;
            if (stop_after > 0 && got_c.size() >= stop_after) break;
            if (cyc >= budget) begin timed_out = 1; break; end
        end
    endtask

    task automatic push3(input logic [16:0] a, input logic [16:0] b, input logic [16:0] c);
        exp_c.push_back(a); exp_p0.push_back(b); exp_p1.push_back(c);
    endtask

    // Reference: a two-pointer merge over whole fibers.
    task automatic model();
        int i, j;
        logic [16:0] a, b, f;
        logic [7:0] la, lb;
        i = 0; j = 0;
        f = value_mode ? Z : EE;
        exp_c.delete(); exp_p0.delete(); exp_p1.delete();
        forever begin
            a = q0c[i]; b = q1c[j];
            if (!a[16] && !b[16]) begin
                if (a == b) begin push3(a, q0p[i], q1p[j]); i++; j++; end
                else if (a < b) begin if (joiner_op) push3(a, q0p[i], f); i++; end
                else begin if (joiner_op) push3(b, f, q1p[j]); j++; end
            end else if (!a[16]) begin
                if (joiner_op) push3(a, q0p[i], f); i++;
            end else if (!b[16]) begin
                if (joiner_op) push3(b, f, q1p[j]); j++;
            end else if (a == DN && b == DN) begin
                push3(DN, DN, DN); break;
            end else if (a == DN) j++;
            else if (b == DN) i++;
            else begin
                la = a[7:0]; lb = b[7:0];
                push3(S0 | 17'(la > lb ? la : lb), S0 | 17'(la > lb ? la : lb), S0 | 17'(la > lb ? la : lb));
                i++; j++;
            end
        end
    endtask

    task automatic gen_stream();
        int nseg;
        logic [16:0] stp;
        nseg = $urandom_range(1, 3);
        q0c.delete(); q0p.delete(); q1c.delete(); q1p.delete();
        for (int s = 0; s < nseg; s++) begin
            stp = (s == nseg - 1) ? S1 : S0;
            for (int k = 0; k < 12; k++) begin
                if ($urandom_range(2) == 0) begin q0c.push_back(17'(k * 5461)); q0p.push_back(17'($urandom_range(65535))); end
                if ($urandom_range(2) == 0) begin q1c.push_back(17'(k * 5461)); q1p.push_back(17'($urandom_range(65535))); end
            end
            q0c.push_back(stp); q0p.push_back(stp); q1c.push_back(stp); q1p.push_back(stp);
        end
        q0c.push_back(DN); q0p.push_back(DN); q1c.push_back(DN); q1p.push_back(DN);
    endtask

    initial begin
        bit to;
        vt[0].op = 0; vt[0].vm = 0; vt[0].n0 = 5; vt[0].n1 = 5; vt[0].nc = 4;
        vt[0].c0  = {17'd1, 17'd3, 17'd5, S0, DN, Z, Z, Z};
        vt[0].p0  = {17'd0, 17'd1, 17'd2, S0, DN, Z, Z, Z};
        vt[0].c1  = {17'd3, 17'd4, 17'd5, S0, DN, Z, Z, Z};
        vt[0].p1  = {17'd0, 17'd1, 17'd2, S0, DN, Z, Z, Z};
        vt[0].ec  = {17'd3, 17'd5, S0, DN, Z, Z, Z, Z};
        vt[0].ep0 = {17'd1, 17'd2, S0, DN, Z, Z, Z, Z};
        vt[0].ep1 = {17'd0, 17'd2, S0, DN, Z, Z, Z, Z};
        vt[1] = vt[0];
        vt[1].op = 1; vt[1].nc = 6;
        vt[1].ec  = {17'd1, 17'd3, 17'd4, 17'd5, S0, DN, Z, Z};
        vt[1].ep0 = {17'd0, 17'd1, EE, 17'd2, S0, DN, Z, Z};
        vt[1].ep1 = {EE, 17'd0, 17'd1, 17'd2, S0, DN, Z, Z};
        vt[2] = vt[1];
        vt[2].vm = 1;
        vt[2].ep0 = {17'd0, 17'd1, Z, 17'd2, S0, DN, Z, Z};
        vt[2].ep1 = {Z, 17'd0, 17'd1, 17'd2, S0, DN, Z, Z};
        vt[3].op = 0; vt[3].vm = 0; vt[3].n0 = 5; vt[3].n1 = 4; vt[3].nc = 4;
        vt[3].c0  = {17'd2, S0, 17'd7, S1, DN, Z, Z, Z};
        vt[3].p0  = {17'd10, S0, 17'd11, S1, DN, Z, Z, Z};
        vt[3].c1  = {17'd2, S0, S1, DN, Z, Z, Z, Z};
        vt[3].p1  = {17'd20, S0, S1, DN, Z, Z, Z, Z};
        vt[3].ec  = {17'd2, S0, S1, DN, Z, Z, Z, Z};
        vt[3].ep0 = {17'd10, S0, S1, DN, Z, Z, Z, Z};
        vt[3].ep1 = {17'd20, S0, S1, DN, Z, Z, Z, Z};

        drive_idle();
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("reset coord_out_valid", 64'(bus.coord_out_valid), 64'd0);
        check("reset pos_out_0_valid", 64'(bus.pos_out_0_valid), 64'd0);
        check("reset pos_out_1_valid", 64'(bus.pos_out_1_valid), 64'd0);
        check("reset coord_in_0_ready", 64'(bus.coord_in_0_ready), 64'd0);
        check("reset pos_in_1_ready", 64'(bus.pos_in_1_ready), 64'd0);
        check("reset coord_out data", 64'(bus.coord_out), 64'd0);

        for (int pass = 0; pass < 2; pass++) begin
            for (int t = 0; t < 4; t++) begin
                joiner_op = vt[t].op; value_mode = vt[t].vm;
                load_vec(t);
                run_stream(400, pass[0], 0, 0, to);
                check($sformatf("vec%0d/%0d timeout", t, pass), 64'(to), 64'd0);
                cmp_all($sformatf("vec%0d/%0d", t, pass));
            end
        end

        joiner_op = 1; value_mode = 0;
        load_vec(1);
        run_stream(400, 0, 10, 0, to);
        check("backpressure timeout", 64'(to), 64'd0);
        cmp_all("backpressure");

        joiner_op = 0; value_mode = 0;
        load_vec(0);
        clk_en = 1'b0;
        run_stream(6, 0, 0, 0, to);
        check("freeze holds", 64'(to), 64'd1);
        check("freeze no output", 64'(got_c.size()), 64'd0);
        check("freeze coord_in_0_ready", 64'(bus.coord_in_0_ready), 64'd0);
        check("freeze coord_out_valid", 64'(bus.coord_out_valid), 64'd0);
        clk_en = 1'b1;
        run_stream(400, 0, 0, 0, to);
        check("after freeze timeout", 64'(to), 64'd0);
        cmp_all("after freeze");

        joiner_op = 1; value_mode = 0;
        load_vec(1);
        run_stream(400, 0, 0, 2, to);
        check("midreset reached 2 outputs", 64'(to), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midreset coord_out_valid", 64'(bus.coord_out_valid), 64'd0);
        check("midreset pos_out_0_valid", 64'(bus.pos_out_0_valid), 64'd0);
        check("midreset pos_out_1_valid", 64'(bus.pos_out_1_valid), 64'd0);
        drive_idle();
        @(negedge clk);
        rst_n = 1'b0;
        joiner_op = 0;
        load_vec(0);
        run_stream(400, 0, 0, 0, to);
        check("post reset timeout", 64'(to), 64'd0);
        cmp_all("post reset");

        for (int it = 0; it < 8; it++) begin
            joiner_op = 1'($urandom_range(1));
            value_mode = 1'($urandom_range(1));
            gen_stream();
            model();
            run_stream(3000, 1, 0, 0, to);
            check($sformatf("rand%0d timeout", it), 64'(to), 64'd0);
            cmp_all($sformatf("rand%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
